// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline front end.
//   NOP_INSTR    : encoding loaded into IF/ID for a bubble (sll $0,$0,0)
//   WORD_W       : instruction / address width
//   JUMP_INDEX_W : width of the pseudo-direct jump index field
//   pc_sel_e     : next-PC source select, listed in priority order
package mips_pkg;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
    localparam int          WORD_W       = 32;
    localparam int          JUMP_INDEX_W = 26;

    typedef enum logic [2:0] {
        PC_RESET,
        PC_BRANCH,
        PC_JUMP,
        PC_HOLD,
        PC_INC
    } pc_sel_e;

endpackage

// File: rtl/instruction_memory.sv
// Instruction memory: IMEM_DEPTH words of WORD_W bits.
//   raddr / rdata : asynchronous read port (word index)
//   we / waddr / wdata : synchronous write port on posedge clk (word index)
// Contents are not reset. A read of a word being written in the same cycle
// returns the old contents, since the write only lands at the edge.
module instruction_memory
    import mips_pkg::*;
#(
    parameter int IMEM_DEPTH = 256,
    localparam int AW = $clog2(IMEM_DEPTH)
) (
    input  logic              clk,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W-1:0] rdata,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata
);

    logic [WORD_W-1:0] mem [IMEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_fetch.sv
// Instruction-fetch stage: PC register, next-PC mux, instruction memory and
// the IF/ID pipeline register feeding instruction_decode.
//   clk, reset            : clock, synchronous active-high reset
//   stall                 : hold PC and IF/ID
//   flush                 : load a bubble into IF/ID (PC follows normal rules)
//   branch_taken/target   : redirect PC to target (bits [1:0] dropped)
//   jump/jump_index       : redirect PC to {pc_plus_4[31:28], index, 00}
//   imem_we/waddr/wdata   : program load port (byte address)
//   pc                    : current fetch PC
//   next_instruction      : IF/ID instruction word
//   pc_plus_4             : IF/ID copy of fetched PC + 4
//   if_valid              : IF/ID holds a real instruction
module instruction_fetch
    import mips_pkg::*;
#(
    parameter int          IMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    flush,
    input  logic                    branch_taken,
    input  logic [WORD_W-1:0]       branch_target,
    input  logic                    jump,
    input  logic [JUMP_INDEX_W-1:0] jump_index,
    input  logic                    imem_we,
    input  logic [WORD_W-1:0]       imem_waddr,
    input  logic [WORD_W-1:0]       imem_wdata,
    output logic [WORD_W-1:0]       pc,
    output logic [WORD_W-1:0]       next_instruction,
    output logic [WORD_W-1:0]       pc_plus_4,
    output logic                    if_valid
);

    localparam int AW = $clog2(IMEM_DEPTH);

    logic [WORD_W-1:0] fetch_word;
    logic [WORD_W-1:0] pc_inc;
    logic [WORD_W-1:0] pc_next;
    logic              redirect;
    pc_sel_e           pc_sel;

    // Byte-offset bits of the byte addresses are don't-care.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{imem_waddr[WORD_W-1:AW+2], imem_waddr[1:0],
                                branch_target[1:0]};

    instruction_memory #(
        .IMEM_DEPTH(IMEM_DEPTH)
    ) u_imem (
        .clk   (clk),
        .raddr (pc[AW+1:2]),
        .rdata (fetch_word),
        .we    (imem_we),
        .waddr (imem_waddr[AW+1:2]),
        .wdata (imem_wdata)
    );

    assign pc_inc   = pc + 32'd4;
    assign redirect = branch_taken | jump;

    always_comb begin
        pc_sel = PC_INC;
        if (reset) begin
            pc_sel = PC_RESET;
        end else if (branch_taken) begin
            pc_sel = PC_BRANCH;
        end else if (jump) begin
            pc_sel = PC_JUMP;
        end else if (stall) begin
            pc_sel = PC_HOLD;
        end
    end

    always_comb begin
        pc_next = pc_inc;
        unique case (pc_sel)
            PC_RESET:  pc_next = RESET_PC;
            PC_BRANCH: pc_next = {branch_target[WORD_W-1:2], 2'b00};
            // Region bits come from the IF/ID copy, i.e. the jump's own PC+4.
            PC_JUMP:   pc_next = {pc_plus_4[WORD_W-1:28], jump_index, 2'b00};
            PC_HOLD:   pc_next = pc;
            PC_INC:    pc_next = pc_inc;
            default:   pc_next = pc_inc;
        endcase
    end

    always_ff @(posedge clk) begin
        pc <= pc_next;
    end

    // A redirect marks the word fetched this cycle as wrong-path and takes
    // precedence over stall so the pipeline cannot hold a dead instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            next_instruction <= NOP_INSTR;
            pc_plus_4        <= '0;
            if_valid         <= 1'b0;
        end else if (redirect || flush) begin
            next_instruction <= NOP_INSTR;
            pc_plus_4        <= pc_inc;
            if_valid         <= 1'b0;
        end else if (!stall) begin
            next_instruction <= fetch_word;
            pc_plus_4        <= pc_inc;
            if_valid         <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset, stall, flush, branch_taken, jump, imem_we;
    logic [31:0] branch_target, imem_waddr, imem_wdata;
    logic [25:0] jump_index;
    logic [31:0] pc, next_instruction, pc_plus_4;
    logic        if_valid;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_pc, m_instr, m_p4;
    logic        m_valid;

    always #5 clk = ~clk;

    instruction_fetch #(.IMEM_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .flush            (flush),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .jump             (jump),
        .jump_index       (jump_index),
        .imem_we          (imem_we),
        .imem_waddr       (imem_waddr),
        .imem_wdata       (imem_wdata),
        .pc               (pc),
        .next_instruction (next_instruction),
        .pc_plus_4        (pc_plus_4),
        .if_valid         (if_valid)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        reset = 0; stall = 0; flush = 0; branch_taken = 0; jump = 0;
        branch_target = 0; jump_index = 0; imem_we = 0; imem_waddr = 0; imem_wdata = 0;
    endtask

    // One clock: predict from the spec rules, clock the DUT, compare everything.
    task automatic step();
        logic [31:0] n_pc, n_instr, n_p4, fetched;
        logic        n_valid;
        fetched = m_mem[m_pc[9:2]];
        n_instr = m_instr; n_p4 = m_p4; n_valid = m_valid;
        if (reset) begin
            n_pc = 32'h0; n_instr = 32'h0; n_p4 = 32'h0; n_valid = 1'b0;
        end else begin
            if (branch_taken)  n_pc = branch_target & 32'hFFFF_FFFC;
            else if (jump)     n_pc = {m_p4[31:28], jump_index, 2'b00};
            else if (stall)    n_pc = m_pc;
            else               n_pc = m_pc + 32'd4;
            if (branch_taken || jump || flush) begin
                n_instr = 32'h0; n_valid = 1'b0;
            end else if (!stall) begin
                n_instr = fetched; n_p4 = m_pc + 32'd4; n_valid = 1'b1;
            end
        end
        @(posedge clk);
        if (imem_we) m_mem[imem_waddr[9:2]] = imem_wdata;
        m_pc = n_pc; m_instr = n_instr; m_p4 = n_p4; m_valid = n_valid;
        #1;
        chk("pc", pc, m_pc);
        chk("instr", next_instruction, m_instr);
        chk("valid", {31'b0, if_valid}, {31'b0, m_valid});
        if (m_valid) chk("pc_plus_4", pc_plus_4, m_p4);
    endtask

    task automatic go_branch(input logic [31:0] tgt);
        idle(); branch_taken = 1; branch_target = tgt; step(); idle();
    endtask

    logic [31:0] prog [4];

    initial begin
        prog[0] = 32'h2008_0001; prog[1] = 32'h2009_0002;
        prog[2] = 32'h0109_5020; prog[3] = 32'hAC0A_0000;
        m_pc = 0; m_instr = 0; m_p4 = 0; m_valid = 0;
        idle();
        reset = 1;
        @(posedge clk); #1;
        // load the whole memory while in reset (writes ignore reset)
        for (int i = 0; i < DEPTH; i++) begin
            imem_we = 1; imem_waddr = i * 4;
            imem_wdata = (i < 4) ? prog[i] : $urandom;
            step();
        end
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", next_instruction, 32'h0);
        chk("rst_valid", {31'b0, if_valid}, 32'h0);
        chk("rst_p4", pc_plus_4, 32'h0);

        // sequential fetch with a 3-cycle stall at pc=8
        idle();
        step(); chk("seq0", next_instruction, prog[0]); chk("seq0_p4", pc_plus_4, 32'd4);
        chk("seq0_v", {31'b0, if_valid}, 32'd1);
        step(); chk("seq1", next_instruction, prog[1]); chk("seq1_p4", pc_plus_4, 32'd8);
        chk("seq_pc8", pc, 32'd8);
        for (int i = 0; i < 3; i++) begin
            stall = 1; step();
            chk("stall_pc", pc, 32'd8); chk("stall_instr", next_instruction, prog[1]);
        end
        idle();
        step(); chk("seq2", next_instruction, prog[2]); chk("seq2_p4", pc_plus_4, 32'd12);
        step(); chk("seq3", next_instruction, prog[3]); chk("seq3_p4", pc_plus_4, 32'd16);

        // branch beats jump and stall; low bits of target dropped
        branch_taken = 1; branch_target = 32'h23; stall = 1; jump = 1; jump_index = 26'h3FF_FFFF;
        step(); idle();
        chk("br_pc", pc, 32'h20); chk("br_valid", {31'b0, if_valid}, 32'd0);
        step(); chk("br_tgt", next_instruction, m_mem[8]);

        // jump from region 0x1
        go_branch(32'h1000_0000);
        step(); chk("j_p4", pc_plus_4, 32'h1000_0004);
        jump = 1; jump_index = 26'h10; step(); idle();
        chk("j_pc", pc, 32'h1000_0040); chk("j_valid", {31'b0, if_valid}, 32'd0);
        step(); chk("j_tgt", next_instruction, m_mem[16]);

        // flush without redirect at pc=0x10
        go_branch(32'h10);
        flush = 1; step(); idle();
        chk("fl_instr", next_instruction, 32'h0); chk("fl_pc", pc, 32'h14);
        chk("fl_valid", {31'b0, if_valid}, 32'd0);
        step(); chk("fl_next", next_instruction, m_mem[5]);

        // write to the word being fetched returns old data
        go_branch(32'h18);
        imem_we = 1; imem_waddr = 32'h18; imem_wdata = 32'hDEAD_BEEF;
        begin
            logic [31:0] old;
            old = m_mem[6];
            step(); idle();
            chk("rdw_old", next_instruction, old);
        end
        go_branch(32'h18); step(); chk("rdw_new", next_instruction, 32'hDEAD_BEEF);

        // wrap cases
        go_branch(32'h3FC); step();
        chk("wrap_pc", pc, 32'h400); chk("wrap_w255", next_instruction, m_mem[255]);
        step(); chk("wrap_w0", next_instruction, m_mem[0]);
        go_branch(32'hFFFF_FFFC); step();
        chk("ovf_pc", pc, 32'h0); chk("ovf_p4", pc_plus_4, 32'h0);
        step(); chk("ovf_w0", next_instruction, m_mem[0]);

        // reset during stall
        stall = 1; reset = 1; step(); idle();
        chk("rst2_pc", pc, 32'h0); chk("rst2_valid", {31'b0, if_valid}, 32'd0);

        // randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            idle();
            reset        = ($urandom_range(99) < 2);
            stall        = ($urandom_range(99) < 25);
            flush        = ($urandom_range(99) < 10);
            branch_taken = ($urandom_range(99) < 8);
            branch_target = ($urandom_range(3) == 0) ? $urandom : $urandom_range(32'h7FF);
            // a jump's region bits are only meaningful when IF/ID holds the jump
            jump         = ($urandom_range(99) < 8) && (m_valid || branch_taken);
            jump_index   = ($urandom_range(1) == 0) ? 26'($urandom) : 26'($urandom_range(511));
            imem_we      = ($urandom_range(99) < 20);
            imem_waddr   = $urandom;
            imem_wdata   = $urandom;
            step();
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
